// File: rtl/panel_timing_pkg.sv
// rtl/panel_timing_pkg.sv - counter widths, region encoding and timing presets for panel_timing_gen
package panel_timing_pkg;

  localparam int H_CNT_W  = 12;
  localparam int V_CNT_W  = 11;
  localparam int HTOT_MAX = 4096;
  localparam int VTOT_MAX = 2048;

  // Region of an axis; the vertical axis region register is the line-level FSM.
  localparam logic [1:0] REG_ACT  = 2'd0;
  localparam logic [1:0] REG_FP   = 2'd1;
  localparam logic [1:0] REG_SYNC = 2'd2;
  localparam logic [1:0] REG_BP   = 2'd3;

  typedef struct packed {
    logic [11:0] active;
    logic [7:0]  fp;
    logic [7:0]  sync;
    logic [7:0]  bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } panel_timing_t;

  localparam panel_timing_t TIMING_1080P = '{
    h: '{12'd1920, 8'd48, 8'd32, 8'd80},
    v: '{12'd1080, 8'd3,  8'd5,  8'd23}};
  localparam panel_timing_t TIMING_768P = '{
    h: '{12'd1366, 8'd70, 8'd143, 8'd213},
    v: '{12'd768,  8'd3,  8'd3,   8'd24}};
  localparam panel_timing_t TIMING_SIM = '{
    h: '{12'd8, 8'd2, 8'd2, 8'd2},
    v: '{12'd4, 8'd1, 8'd1, 8'd1}};

  function automatic logic [3:0] clamp_pat(input logic [3:0] sel, input int num_pat);
    if (int'(sel) > num_pat - 1) return 4'(num_pat - 1);
    return sel;
  endfunction

endpackage

// File: rtl/panel_axis_cnt.sv
// rtl/panel_axis_cnt.sv - one raster axis: position counter plus active/FP/sync/BP region register
module panel_axis_cnt
  import panel_timing_pkg::*;
#(
  parameter int ACTIVE = 8,
  parameter int FP     = 2,
  parameter int SYNC   = 2,
  parameter int BP     = 2,
  parameter int W      = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic [1:0]   region,
  output logic         wrap
);

  localparam logic [W-1:0] END_ACT  = W'(ACTIVE - 1);
  localparam logic [W-1:0] END_FP   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] END_SYNC = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] END_BP   = W'(ACTIVE + FP + SYNC + BP - 1);

  logic region_end;

  always_comb begin
    region_end = 1'b0;
    case (region)
      REG_ACT:  region_end = (cnt == END_ACT);
      REG_FP:   region_end = (cnt == END_FP);
      REG_SYNC: region_end = (cnt == END_SYNC);
      default:  region_end = (cnt == END_BP);
    endcase
  end

  assign wrap = (region == REG_BP) && region_end;

  // Region advances in order and wraps BP -> active with the 2-bit increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      region <= REG_ACT;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (region_end) region <= region + 2'd1;
    end
  end

endmodule

// File: rtl/panel_timing_gen.sv
// rtl/panel_timing_gen.sv - raster HS/VS/DE/X/Y generator with frame-aligned pattern index
module panel_timing_gen
  import panel_timing_pkg::*;
#(
  parameter int   H_ACTIVE = int'(TIMING_1080P.h.active),
  parameter int   H_FP     = int'(TIMING_1080P.h.fp),
  parameter int   H_SYNC   = int'(TIMING_1080P.h.sync),
  parameter int   H_BP     = int'(TIMING_1080P.h.bp),
  parameter int   V_ACTIVE = int'(TIMING_1080P.v.active),
  parameter int   V_FP     = int'(TIMING_1080P.v.fp),
  parameter int   V_SYNC   = int'(TIMING_1080P.v.sync),
  parameter int   V_BP     = int'(TIMING_1080P.v.bp),
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   NUM_PAT  = 16
) (
  input  logic        iclk,
  input  logic        iRESET,
  input  logic        iEN,
  input  logic        iPAT_NEXT,
  input  logic        iPAT_LOAD,
  input  logic [3:0]  iPAT_SEL,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic [11:0] oX,
  output logic [10:0] oY,
  output logic        oFRAME_START,
  output logic [7:0]  oFRAME_CNT,
  output logic [3:0]  oPAT
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTOT > HTOT_MAX || VTOT > VTOT_MAX || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      NUM_PAT < 1 || NUM_PAT > 16) begin : g_bad_timing
    $error("panel_timing_gen: timing parameters out of range");
  end

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_LOAD = 2'd1;
  localparam logic [1:0] REQ_NEXT = 2'd2;

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic [1:0]         h_region, v_region;
  logic               h_wrap, v_wrap;
  logic               at_origin, boundary, de;
  logic [1:0]         req_kind;
  logic [3:0]         req_sel, pat_step;

  panel_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(H_CNT_W)) u_h_axis (
    .clk(iclk), .rst_n(iRESET), .step(iEN),
    .cnt(h_cnt), .region(h_region), .wrap(h_wrap));

  panel_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(V_CNT_W)) u_v_axis (
    .clk(iclk), .rst_n(iRESET), .step(iEN && h_wrap),
    .cnt(v_cnt), .region(v_region), .wrap(v_wrap));

  // at_origin tracks "counters sit at (0,0)" without a full-width compare.
  assign boundary = iEN && at_origin;
  assign de       = iEN && (h_region == REG_ACT) && (v_region == REG_ACT);
  assign pat_step = (oPAT == 4'(NUM_PAT - 1)) ? 4'd0 : oPAT + 4'd1;

  always_ff @(posedge iclk or negedge iRESET) begin
    if (!iRESET) begin
      oHS          <= ~HS_POL;
      oVS          <= ~VS_POL;
      oDE          <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oFRAME_START <= 1'b0;
      oFRAME_CNT   <= '0;
      oPAT         <= '0;
      at_origin    <= 1'b1;
      req_kind     <= REQ_NONE;
      req_sel      <= '0;
    end else begin
      oDE          <= de;
      oHS          <= (iEN && h_region == REG_SYNC) ? HS_POL : ~HS_POL;
      oVS          <= (iEN && v_region == REG_SYNC) ? VS_POL : ~VS_POL;
      oX           <= de ? h_cnt : '0;
      oY           <= de ? v_cnt : '0;
      oFRAME_START <= boundary;
      if (iEN) at_origin <= h_wrap && v_wrap;
      if (boundary) begin
        oFRAME_CNT <= oFRAME_CNT + 8'd1;
        case (req_kind)
          REQ_LOAD: oPAT <= req_sel;
          REQ_NEXT: oPAT <= pat_step;
          default:  ;
        endcase
      end
      // A request seen on the boundary cycle itself stays pending for the next frame.
      if (iPAT_LOAD) begin
        req_kind <= REQ_LOAD;
        req_sel  <= clamp_pat(iPAT_SEL, NUM_PAT);
      end else if (iPAT_NEXT) begin
        req_kind <= REQ_NEXT;
      end else if (boundary) begin
        req_kind <= REQ_NONE;
      end
    end
  end

endmodule

// File: tb/tb_panel_timing_gen.sv
// tb/tb_panel_timing_gen.sv - self-checking bench for panel_timing_gen using sim-small timing
module tb_panel_timing_gen;
  import panel_timing_pkg::*;

  localparam int HA   = int'(TIMING_SIM.h.active);
  localparam int HF   = int'(TIMING_SIM.h.fp);
  localparam int H_SY = int'(TIMING_SIM.h.sync);
  localparam int HB   = int'(TIMING_SIM.h.bp);
  localparam int VA   = int'(TIMING_SIM.v.active);
  localparam int VF   = int'(TIMING_SIM.v.fp);
  localparam int V_SY = int'(TIMING_SIM.v.sync);
  localparam int VB   = int'(TIMING_SIM.v.bp);
  localparam int HTOT = HA + HF + H_SY + HB;
  localparam int VTOT = VA + VF + V_SY + VB;
  localparam int FTOT = HTOT * VTOT;
  localparam int NPAT = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pat_next = 1'b0, pat_load = 1'b0;
  logic [3:0] pat_sel = 4'd0;

  logic oHS, oVS, oDE, oFS;
  logic [11:0] oX;
  logic [10:0] oY;
  logic [7:0] oFCNT;
  logic [3:0] oPAT;
  logic p_hs, p_vs, p_de, p_fs;
  logic [11:0] p_x;
  logic [10:0] p_y;
  logic [7:0] p_fcnt;
  logic [3:0] p_pat;

  panel_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(H_SY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(V_SY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .NUM_PAT(NPAT)) dut (
    .iclk(clk), .iRESET(rst_n), .iEN(en), .iPAT_NEXT(pat_next), .iPAT_LOAD(pat_load),
    .iPAT_SEL(pat_sel), .oHS(oHS), .oVS(oVS), .oDE(oDE), .oX(oX), .oY(oY),
    .oFRAME_START(oFS), .oFRAME_CNT(oFCNT), .oPAT(oPAT));

  panel_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(H_SY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(V_SY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .NUM_PAT(NPAT)) dut_p (
    .iclk(clk), .iRESET(rst_n), .iEN(en), .iPAT_NEXT(pat_next), .iPAT_LOAD(pat_load),
    .iPAT_SEL(pat_sel), .oHS(p_hs), .oVS(p_vs), .oDE(p_de), .oX(p_x), .oY(p_y),
    .oFRAME_START(p_fs), .oFRAME_CNT(p_fcnt), .oPAT(p_pat));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position comes from the count of enabled clocks, not from region state.
  int n, m_fcnt, m_pat, req_kind, req_sel, e_x, e_y;
  logic e_de, e_hs_act, e_vs_act, e_fs;

  always @(posedge clk or negedge rst_n) begin
    int p, h, v;
    if (!rst_n) begin
      n = 0; m_fcnt = 0; m_pat = 0; req_kind = 0; req_sel = 0;
      e_de = 0; e_hs_act = 0; e_vs_act = 0; e_fs = 0; e_x = 0; e_y = 0;
    end else begin
      e_de = 0; e_hs_act = 0; e_vs_act = 0; e_fs = 0; e_x = 0; e_y = 0;
      if (en) begin
        p = n % FTOT; h = p % HTOT; v = p / HTOT; n++;
        e_de     = (h < HA) && (v < VA);
        e_hs_act = (h >= HA + HF) && (h < HA + HF + H_SY);
        e_vs_act = (v >= VA + VF) && (v < VA + VF + V_SY);
        e_fs     = (p == 0);
        if (e_de) begin e_x = h; e_y = v; end
      end
      if (e_fs) begin
        m_fcnt = (m_fcnt + 1) % 256;
        if (req_kind == 1) m_pat = (req_sel > NPAT - 1) ? NPAT - 1 : req_sel;
        else if (req_kind == 2) m_pat = (m_pat + 1) % NPAT;
        req_kind = 0;
      end
      if (pat_load) begin req_kind = 1; req_sel = int'(pat_sel); end
      else if (pat_next) req_kind = 2;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("cycle", {oHS, oVS, oDE, oX, oY, oFS, oFCNT, oPAT},
          {~e_hs_act, ~e_vs_act, e_de, 12'(e_x), 11'(e_y), e_fs, 8'(m_fcnt), 4'(m_pat)});
      chk("cycle_pol", {p_hs, p_vs, p_de, p_x, p_y, p_fs, p_fcnt, p_pat},
          {e_hs_act, e_vs_act, e_de, 12'(e_x), 11'(e_y), e_fs, 8'(m_fcnt), 4'(m_pat)});
    end
  end

  task automatic wait_fs(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!oFS && cycles < 300);
    if (!oFS) begin
      checks++;
      failures++;
      $display("FAIL wait_fs: no frame start within %0d cycles", cycles);
    end
  endtask

  task automatic pulse(input logic load, input logic next, input logic [3:0] sel);
    pat_load = load; pat_next = next; pat_sel = sel;
    @(negedge clk);
    pat_load = 1'b0; pat_next = 1'b0;
  endtask

  typedef struct {
    logic en;
    logic de;
    int   x;
    int   y;
    logic hs;
    logic fs;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int c, len, de_n, hs_n, vs_n;
    // Expected first line after reset (h = index), then a 3-clock hold, then line 1 start.
    tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4, 0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 5, 0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 6, 0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 7, 0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 0, 1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    chk("reset_state", {oHS, oVS, oDE, oX, oY, oFS, oFCNT, oPAT, p_hs, p_vs},
        {1'b1, 1'b1, 1'b0, 12'd0, 11'd0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0});
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      en = tbl[k].en;
      @(negedge clk);
      chk($sformatf("vec%0d", k), {oDE, oX, oY, oHS, p_hs, oFS},
          {tbl[k].de, 12'(tbl[k].x), 11'(tbl[k].y), tbl[k].hs, ~tbl[k].hs, tbl[k].fs});
    end

    // One full frame: length, DE clocks, HS/VS low clocks.
    wait_fs(c);
    len = 0; de_n = 0; hs_n = 0; vs_n = 0;
    do begin
      if (oDE) de_n++;
      if (!oHS) hs_n++;
      if (!oVS) vs_n++;
      @(negedge clk);
      len++;
    end while (!oFS && len < 300);
    chk("frame_len", len, FTOT);
    chk("de_clocks", de_n, HA * VA);
    chk("hs_low_clocks", hs_n, H_SY * VTOT);
    chk("vs_low_clocks", vs_n, V_SY * HTOT);

    // Pattern requests applied only at frame start.
    pulse(1'b1, 1'b0, 4'd3);
    wait_fs(c);
    chk("pat_load3", oPAT, 3);
    repeat (20) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd0);
    repeat (5) @(negedge clk);
    chk("pat_hold", oPAT, 3);
    wait_fs(c);
    chk("pat_next_wrap", oPAT, 0);
    repeat (10) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd0);
    repeat (15) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd0);
    repeat (30) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd0);
    wait_fs(c);
    chk("pat_multi_next", oPAT, 1);

    pulse(1'b1, 1'b1, 4'd9);
    wait_fs(c);
    chk("pat_load_clamp_wins", oPAT, 3);
    repeat (FTOT - 1) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd0);
    chk("bnd_fs", oFS, 1);
    chk("bnd_pat_hold", oPAT, 3);
    wait_fs(c);
    chk("bnd_applied", oPAT, 0);

    // Enable hold for 20 clocks mid-line.
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_off_idle", {oDE, oX, oY, oHS, oVS, oFS, p_hs, p_vs},
        {1'b0, 12'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (18) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("resume_x", oX, 4);
    wait_fs(c);
    chk("en_frame_len", c + 24, FTOT + 20);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      pat_next = ($urandom_range(0, 40) == 0);
      pat_load = ($urandom_range(0, 60) == 0);
      pat_sel  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    en = 1'b1; pat_next = 1'b0; pat_load = 1'b0;

    // Asynchronous reset between edges, then frame counter wrap.
    pulse(1'b1, 1'b0, 4'd2);
    wait_fs(c);
    repeat (5) @(negedge clk);
    chk("pre_reset_pat", oPAT, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {oHS, oVS, oDE, oX, oY, oFS, oFCNT, oPAT, p_hs, p_vs},
        {1'b1, 1'b1, 1'b0, 12'd0, 11'd0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1 + 254 * FTOT) @(negedge clk);
    chk("fcnt_255", oFCNT, 255);
    repeat (FTOT) @(negedge clk);
    chk("fcnt_wrap", oFCNT, 0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
